// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus cycle sequencer: request encodings,
// T-state constants and the active-low strobe bundle.
package z80_bus_pkg;

    // Request types issued by the execution core
    localparam logic [2:0] REQ_FETCH = 3'd0;
    localparam logic [2:0] REQ_MEMRD = 3'd1;
    localparam logic [2:0] REQ_MEMWR = 3'd2;
    localparam logic [2:0] REQ_IORD  = 3'd3;
    localparam logic [2:0] REQ_IOWR  = 3'd4;

    // Machine-cycle T-states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_T1    = 3'd1;
    localparam logic [2:0] ST_T2    = 3'd2;
    localparam logic [2:0] ST_TW    = 3'd3;
    localparam logic [2:0] ST_T3    = 3'd4;
    localparam logic [2:0] ST_T4    = 3'd5;
    localparam logic [2:0] ST_BUSAK = 3'd6;

    // Bus strobes, all active low
    typedef struct packed {
        logic n_m1;
        logic n_mreq;
        logic n_iorq;
        logic n_rd;
        logic n_wr;
        logic n_rfsh;
    } strobe_t;

    localparam strobe_t STROBES_OFF = '{default: 1'b1};

    function automatic logic is_io(input logic [2:0] t);
        return (t == REQ_IORD) || (t == REQ_IOWR);
    endfunction

    function automatic logic is_write(input logic [2:0] t);
        return (t == REQ_MEMWR) || (t == REQ_IOWR);
    endfunction

    function automatic logic is_read(input logic [2:0] t);
        return (t == REQ_MEMRD) || (t == REQ_IORD);
    endfunction

endpackage

// File: rtl/z80_rfsh_counter.sv
// Wrapping DRAM refresh counter; supplies the low address bits during refresh.
module z80_rfsh_counter #(
    parameter int W = 7
) (
    input  logic         CLK,
    input  logic         n_RESET,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Advance once per completed opcode fetch, wrapping modulo 2^W
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/z80_bus_cycle_gen.sv
// Z80 machine-cycle sequencer: turns single core requests into T-state
// accurate bus strobes, with wait stretching and bus release.
module z80_bus_cycle_gen
    import z80_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int RFSH_W  = 7,
    parameter int IO_WAIT = 1
) (
    input  logic                 CLK,
    input  logic                 n_RESET,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_type,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [ADDR_W-RFSH_W-1:0] rfsh_hi,
    output logic                 done,
    output logic [DATA_W-1:0]    rdata,
    output logic [ADDR_W-1:0]    A,
    output logic                 a_oe,
    input  logic [DATA_W-1:0]    d_in,
    output logic [DATA_W-1:0]    d_out,
    output logic                 d_oe,
    output logic                 n_M1,
    output logic                 n_MREQ,
    output logic                 n_IORQ,
    output logic                 n_RD,
    output logic                 n_WR,
    output logic                 n_RFSH,
    input  logic                 n_WAIT,
    input  logic                 n_BUSREQ,
    output logic                 n_BUSACK
);

    localparam logic [2:0] IO_WAIT_L = 3'(IO_WAIT);

    logic [2:0]              state;
    logic [2:0]              type_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [ADDR_W-RFSH_W-1:0] rfsh_hi_q;
    logic [2:0]              wait_cnt;
    logic [RFSH_W-1:0]       rfsh_cnt;
    logic [ADDR_W-1:0]       rfsh_addr;
    logic                    rfsh_inc;
    strobe_t                 strb;

    assign rfsh_inc  = (state == ST_T4);
    assign rfsh_addr = {rfsh_hi_q, rfsh_cnt};

    z80_rfsh_counter #(.W(RFSH_W)) u_rfsh (
        .CLK     (CLK),
        .n_RESET (n_RESET),
        .inc     (rfsh_inc),
        .cnt     (rfsh_cnt)
    );

    // T-state sequencing, request latching, wait counting and data capture
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            state     <= ST_IDLE;
            type_q    <= REQ_FETCH;
            addr_q    <= '0;
            wdata_q   <= '0;
            rfsh_hi_q <= '0;
            wait_cnt  <= '0;
            rdata     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!n_BUSREQ) begin
                        state <= ST_BUSAK;
                    end else if (req_valid) begin
                        type_q    <= req_type;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rfsh_hi_q <= rfsh_hi;
                        wait_cnt  <= is_io(req_type) ? IO_WAIT_L : 3'd0;
                        if (req_type <= REQ_IOWR) begin
                            state <= ST_T1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_T1: state <= ST_T2;
                ST_T2, ST_TW: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                        state    <= ST_TW;
                    end else if (!n_WAIT) begin
                        state <= ST_TW;
                    end else begin
                        state <= ST_T3;
                        if (type_q == REQ_FETCH) begin
                            rdata <= d_in;
                        end
                    end
                end
                ST_T3: begin
                    if (type_q == REQ_FETCH) begin
                        state <= ST_T4;
                    end else begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        if (is_read(type_q)) begin
                            rdata <= d_in;
                        end
                    end
                end
                ST_T4: begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                ST_BUSAK: begin
                    if (n_BUSREQ) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decode strobes, address source and drive enables from the current T-state
    always_comb begin
        strb = STROBES_OFF;
        A    = addr_q;
        a_oe = 1'b1;
        d_oe = 1'b0;
        case (state)
            ST_T1: begin
                strb.n_m1 = (type_q != REQ_FETCH);
                d_oe      = is_write(type_q);
            end
            ST_T2, ST_TW, ST_T3: begin
                d_oe = is_write(type_q);
                if (type_q == REQ_FETCH) begin
                    if (state == ST_T3) begin
                        strb.n_mreq = 1'b0;
                        strb.n_rfsh = 1'b0;
                        A           = rfsh_addr;
                    end else begin
                        strb.n_m1   = 1'b0;
                        strb.n_mreq = 1'b0;
                        strb.n_rd   = 1'b0;
                    end
                end else begin
                    strb.n_mreq = is_io(type_q);
                    strb.n_iorq = !is_io(type_q);
                    strb.n_rd   = !is_read(type_q);
                    strb.n_wr   = !is_write(type_q);
                end
            end
            ST_T4: begin
                strb.n_rfsh = 1'b0;
                A           = rfsh_addr;
            end
            ST_BUSAK: a_oe = 1'b0;
            default: ;
        endcase
    end

    assign d_out     = wdata_q;
    assign n_M1      = strb.n_m1;
    assign n_MREQ    = strb.n_mreq;
    assign n_IORQ    = strb.n_iorq;
    assign n_RD      = strb.n_rd;
    assign n_WR      = strb.n_wr;
    assign n_RFSH    = strb.n_rfsh;
    assign n_BUSACK  = (state != ST_BUSAK);
    assign req_ready = (state == ST_IDLE) && n_BUSREQ;

endmodule

// File: tb/tb_z80_bus_cycle_gen.sv
// Self-checking bench for z80_bus_cycle_gen: directed scenarios plus random
// transactions, compared cycle by cycle against a transaction-level model.
module tb_z80_bus_cycle_gen;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int RFSH_W  = 7;
    localparam int IO_WAIT = 1;
    localparam int HI_W    = ADDR_W - RFSH_W;

    localparam int PT1 = 1;
    localparam int PT2 = 2;
    localparam int PTW = 3;
    localparam int PT3 = 4;
    localparam int PT4 = 5;

    logic              CLK;
    logic              n_RESET;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [HI_W-1:0]   rfsh_hi;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] A;
    logic              a_oe;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;
    logic              n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH;
    logic              n_WAIT;
    logic              n_BUSREQ;
    logic              n_BUSACK;

    logic [10:0]       obs;
    int                checks;
    int                fails;
    logic [RFSH_W-1:0] rfsh_m;
    logic [DATA_W-1:0] rdata_m;

    z80_bus_cycle_gen #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RFSH_W  (RFSH_W),
        .IO_WAIT (IO_WAIT)
    ) dut (
        .CLK       (CLK),
        .n_RESET   (n_RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rfsh_hi   (rfsh_hi),
        .done      (done),
        .rdata     (rdata),
        .A         (A),
        .a_oe      (a_oe),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .n_M1      (n_M1),
        .n_MREQ    (n_MREQ),
        .n_IORQ    (n_IORQ),
        .n_RD      (n_RD),
        .n_WR      (n_WR),
        .n_RFSH    (n_RFSH),
        .n_WAIT    (n_WAIT),
        .n_BUSREQ  (n_BUSREQ),
        .n_BUSACK  (n_BUSACK)
    );

    assign obs = {n_M1, n_MREQ, n_IORQ, n_RD, n_WR, n_RFSH, n_BUSACK, a_oe, d_oe, done, req_ready};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Strobes the bus should show in a given T-state of a given cycle type
    function automatic logic [5:0] expStrobes(input int ph, input logic [2:0] t);
        logic m1, mreq, iorq, rd, wr, rf;
        m1 = 0; mreq = 0; iorq = 0; rd = 0; wr = 0; rf = 0;
        if (t == 3'd0) begin
            m1   = (ph == PT1) || (ph == PT2) || (ph == PTW);
            mreq = (ph == PT2) || (ph == PTW) || (ph == PT3);
            rd   = (ph == PT2) || (ph == PTW);
            rf   = (ph == PT3) || (ph == PT4);
        end else if (t <= 3'd4 && ph >= PT2 && ph <= PT3) begin
            mreq = (t == 3'd1) || (t == 3'd2);
            iorq = (t == 3'd3) || (t == 3'd4);
            rd   = (t == 3'd1) || (t == 3'd3);
            wr   = (t == 3'd2) || (t == 3'd4);
        end
        return ~{m1, mreq, iorq, rd, wr, rf};
    endfunction

    function automatic logic [10:0] idleVec(input logic dn, input logic rdy);
        return {6'h3F, 1'b1, 1'b1, 1'b0, dn, rdy};
    endfunction

    // Run one transaction from an IDLE-cycle negedge to its done-cycle negedge.
    // k = extra n_WAIT cycles; busreq_at/rst_at = cycle index for events (-1 = none)
    task automatic applyStimulus(input logic [2:0] t, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wd, input int k,
                                 input logic [DATA_W-1:0] din, input logic [HI_W-1:0] rhi,
                                 input int busreq_at, input int rst_at);
        int forced, n, cap, ph;
        logic wr;
        logic [ADDR_W-1:0] expA;
        forced = (t == 3'd3 || t == 3'd4) ? IO_WAIT : 0;
        n      = (t <= 3'd4) ? (3 + forced + k + ((t == 3'd0) ? 1 : 0)) : 0;
        cap    = (t == 3'd0) ? (1 + forced + k) : ((t == 3'd1 || t == 3'd3) ? n - 1 : -1);
        wr     = (t == 3'd2) || (t == 3'd4);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = addr;
        req_wdata = wd;
        rfsh_hi   = rhi;
        @(posedge CLK);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (i == 0)                     ph = PT1;
            else if (i == 1)                ph = PT2;
            else if (i <= 1 + forced + k)   ph = PTW;
            else if (i == 2 + forced + k)   ph = PT3;
            else                            ph = PT4;
            checkOutput("cycle", 32'(obs), 32'({expStrobes(ph, t), 1'b1, 1'b1, wr, 1'b0, 1'b0}));
            expA = (t == 3'd0 && ph >= PT3) ? {rhi, rfsh_m} : addr;
            checkOutput("addr", 32'(A), 32'(expA));
            if (wr) checkOutput("d_out", 32'(d_out), 32'(wd));
            if (i == rst_at) begin
                n_RESET = 1'b0;
                #1;
                checkOutput("rst_vec", 32'(obs), 32'(idleVec(1'b0, 1'b1)));
                checkOutput("rst_A", 32'(A), 32'd0);
                checkOutput("rst_rdata", 32'(rdata), 32'd0);
                rdata_m   = '0;
                rfsh_m    = '0;
                req_valid = 1'b0;
                n_WAIT    = 1'b1;
                #2 n_RESET = 1'b1;
                @(negedge CLK);
                checkOutput("post_rst", 32'(obs), 32'(idleVec(1'b0, 1'b1)));
                return;
            end
            req_valid = 1'b0;
            n_WAIT    = (i >= 1 && i <= forced + k) ? 1'b0 : 1'b1;
            d_in      = (i == cap) ? din : ~din;
            if (i == busreq_at) n_BUSREQ = 1'b0;
        end
        if (t == 3'd0) rfsh_m = rfsh_m + 1'b1;
        if (cap >= 0) rdata_m = din;
        @(negedge CLK);
        req_valid = 1'b0;
        checkOutput("done", 32'(obs), 32'(idleVec(1'b1, n_BUSREQ)));
        checkOutput("rdata", 32'(rdata), 32'(rdata_m));
    endtask

    task automatic idleCycle();
        @(negedge CLK);
        checkOutput("idle", 32'(obs), 32'(idleVec(1'b0, 1'b1)));
    endtask

    // Hold the bus granted for m cycles, then release it and drop any pending request
    task automatic busakHold(input int m);
        for (int i = 0; i < m; i++) begin
            @(negedge CLK);
            checkOutput("busak", 32'(obs), 32'({6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        end
        n_BUSREQ  = 1'b1;
        req_valid = 1'b0;
        @(negedge CLK);
        checkOutput("release", 32'(obs), 32'(idleVec(1'b0, 1'b1)));
    endtask

    initial begin
        #500000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        logic [2:0] t;
        int k;
        checks    = 0;
        fails     = 0;
        rfsh_m    = '0;
        rdata_m   = '0;
        n_RESET   = 1'b0;
        req_valid = 1'b0;
        req_type  = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        rfsh_hi   = '0;
        d_in      = '0;
        n_WAIT    = 1'b1;
        n_BUSREQ  = 1'b1;

        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset_vec", 32'(obs), 32'(idleVec(1'b0, 1'b1)));
        checkOutput("reset_A", 32'(A), 32'd0);
        checkOutput("reset_dout", 32'(d_out), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        #2 n_RESET = 1'b1;
        idleCycle();

        $display("[TB] MEMRD then back-to-back MEMWR");
        applyStimulus(3'd1, 16'h1234, 8'h00, 0, 8'hA5, 9'h000, -1, -1);
        applyStimulus(3'd2, 16'h4321, 8'h5A, 1, 8'h00, 9'h000, -1, -1);
        idleCycle();

        $display("[TB] IOWR with extended waits");
        applyStimulus(3'd4, 16'h00FE, 8'hC3, 3, 8'h00, 9'h000, -1, -1);
        applyStimulus(3'd3, 16'h0077, 8'h00, 0, 8'h3C, 9'h000, -1, -1);

        $display("[TB] reserved request types");
        applyStimulus(3'd5, 16'hBEEF, 8'h11, 0, 8'h99, 9'h000, -1, -1);
        applyStimulus(3'd7, 16'hCAFE, 8'h22, 0, 8'h88, 9'h000, -1, -1);

        $display("[TB] bus request during MEMWR");
        applyStimulus(3'd2, 16'h8000, 8'h7E, 1, 8'h00, 9'h000, 1, -1);
        busakHold(3);

        $display("[TB] bus request beats pending request in IDLE");
        n_BUSREQ  = 1'b0;
        req_valid = 1'b1;
        req_type  = 3'd1;
        busakHold(2);
        idleCycle();

        $display("[TB] refresh counter wrap");
        while (rfsh_m != 7'h7F)
            applyStimulus(3'd0, 16'($urandom), 8'h00, int'($urandom_range(0, 1)),
                          8'($urandom), 9'($urandom), -1, -1);
        applyStimulus(3'd0, 16'h0100, 8'h00, 0, 8'h3E, 9'h03F, -1, -1);
        applyStimulus(3'd0, 16'h0101, 8'h00, 0, 8'h4F, 9'h03F, -1, -1);

        $display("[TB] reset during fetch wait");
        applyStimulus(3'd0, 16'h2222, 8'h00, 2, 8'h66, 9'h1AA, -1, 2);
        applyStimulus(3'd0, 16'h2223, 8'h00, 0, 8'h67, 9'h1AA, -1, -1);

        $display("[TB] random transactions");
        for (int j = 0; j < 80; j++) begin
            t = 3'($urandom_range(0, 7));
            k = int'($urandom_range(0, 3));
            if (t <= 3'd4 && $urandom_range(0, 7) == 0) begin
                applyStimulus(t, 16'($urandom), 8'($urandom), k, 8'($urandom),
                              9'($urandom), 1, -1);
                busakHold(int'($urandom_range(1, 3)));
            end else begin
                applyStimulus(t, 16'($urandom), 8'($urandom), k, 8'($urandom),
                              9'($urandom), -1, -1);
                if ($urandom_range(0, 3) == 0) idleCycle();
            end
        end

        idleCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
